// File: rtl/stack_ctrl_if.sv
// Request, stack-pointer and data-memory signals of the stack sequencer.
// The slave modport is the sequencer; the master modport is the pipeline/memory side.
interface stack_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              op_valid;
    logic [2:0]        op;
    logic [31:0]       op_data;
    logic              op_ready;
    logic [31:0]       sp_read_data;
    logic [31:0]       sp_write_data;
    logic              sp_write_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;
    logic [31:0]       pop_data;
    logic              done;
    logic              fault;

    modport slave (
        input  op_valid, op, op_data, sp_read_data, mem_rdata,
        output op_ready, sp_write_data, sp_write_enable, mem_addr,
               mem_wdata, mem_we, mem_re, pop_data, done, fault
    );

    modport master (
        output op_valid, op, op_data, sp_read_data, mem_rdata,
        input  op_ready, sp_write_data, sp_write_enable, mem_addr,
               mem_wdata, mem_we, mem_re, pop_data, done, fault
    );
endinterface

// File: rtl/stack_ctrl.sv
// Memory-stage stack sequencer: PUSH/POP of 16-bit words and 32-bit PC pairs on a downward stack.
// Define STACK_BOUNDS_CHECK_EN to reject out-of-range pushes/pops with a fault pulse.
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP = 32'd2047,
    parameter int          ADDR_W    = 11
) (
    input  logic         clk,
    input  logic         reset,
    stack_ctrl_if.slave  bus
);

    localparam logic [2:0] OP_PUSH16 = 3'd1;
    localparam logic [2:0] OP_POP16  = 3'd2;
    localparam logic [2:0] OP_PUSH32 = 3'd3;
    localparam logic [2:0] OP_POP32  = 3'd4;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BoundsCheck = 1'b1;
`else
    localparam bit BoundsCheck = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PUSH_LO,
        POP_WAIT,
        POP_LO_WAIT,
        POP_HI_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] baseSp_q, baseSp_d;
    logic [15:0] pushLo_q, pushLo_d;
    logic [15:0] lowWord_q, lowWord_d;
    logic [31:0] popData_q, popData_d;

    logic [31:0] spIn;
    logic [31:0] memAddr32;
    logic [15:0] memWdata;
    logic        memWe;
    logic        memRe;
    logic [31:0] spWdata;
    logic        spWe;
    logic        donePulse;
    logic        faultPulse;
    logic        pushOk1, pushOk2, popOk1, popOk2;

    assign spIn = bus.sp_read_data;

    // Pop bound is evaluated at 33 bits so an SP near 2^32 cannot wrap past the limit.
    assign pushOk1 = !BoundsCheck || (spIn >= 32'd1);
    assign pushOk2 = !BoundsCheck || (spIn >= 32'd2);
    assign popOk1  = !BoundsCheck || ((33'(spIn) + 33'd1) <= 33'(STACK_TOP));
    assign popOk2  = !BoundsCheck || ((33'(spIn) + 33'd2) <= 33'(STACK_TOP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baseSp_q  <= '0;
            pushLo_q  <= '0;
            lowWord_q <= '0;
            popData_q <= '0;
        end else begin
            state_q   <= state_d;
            baseSp_q  <= baseSp_d;
            pushLo_q  <= pushLo_d;
            lowWord_q <= lowWord_d;
            popData_q <= popData_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baseSp_d   = baseSp_q;
        pushLo_d   = pushLo_q;
        lowWord_d  = lowWord_q;
        popData_d  = popData_q;
        memAddr32  = '0;
        memWdata   = '0;
        memWe      = 1'b0;
        memRe      = 1'b0;
        spWdata    = '0;
        spWe       = 1'b0;
        donePulse  = 1'b0;
        faultPulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    baseSp_d = spIn;
                    pushLo_d = bus.op_data[15:0];
                    case (bus.op)
                        OP_PUSH16: begin
                            if (pushOk1) begin
                                memWe     = 1'b1;
                                memAddr32 = spIn;
                                memWdata  = bus.op_data[15:0];
                                spWdata   = spIn - 32'd1;
                                spWe      = 1'b1;
                                donePulse = 1'b1;
                            end else begin
                                faultPulse = 1'b1;
                            end
                        end
                        OP_PUSH32: begin
                            if (pushOk2) begin
                                memWe     = 1'b1;
                                memAddr32 = spIn;
                                memWdata  = bus.op_data[31:16];
                                state_d   = PUSH_LO;
                            end else begin
                                faultPulse = 1'b1;
                            end
                        end
                        OP_POP16: begin
                            if (popOk1) begin
                                memRe     = 1'b1;
                                memAddr32 = spIn + 32'd1;
                                state_d   = POP_WAIT;
                            end else begin
                                faultPulse = 1'b1;
                            end
                        end
                        OP_POP32: begin
                            if (popOk2) begin
                                memRe     = 1'b1;
                                memAddr32 = spIn + 32'd1;
                                state_d   = POP_LO_WAIT;
                            end else begin
                                faultPulse = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            PUSH_LO: begin
                memWe     = 1'b1;
                memAddr32 = baseSp_q - 32'd1;
                memWdata  = pushLo_q;
                spWdata   = baseSp_q - 32'd2;
                spWe      = 1'b1;
                donePulse = 1'b1;
                state_d   = IDLE;
            end
            POP_WAIT: begin
                popData_d = {16'b0, bus.mem_rdata};
                spWdata   = baseSp_q + 32'd1;
                spWe      = 1'b1;
                donePulse = 1'b1;
                state_d   = IDLE;
            end
            POP_LO_WAIT: begin
                lowWord_d = bus.mem_rdata;
                memRe     = 1'b1;
                memAddr32 = baseSp_q + 32'd2;
                state_d   = POP_HI_WAIT;
            end
            POP_HI_WAIT: begin
                popData_d = {bus.mem_rdata, lowWord_q};
                spWdata   = baseSp_q + 32'd2;
                spWe      = 1'b1;
                donePulse = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.op_ready        = (state_q == IDLE);
    assign bus.mem_addr        = ADDR_W'(memAddr32);
    assign bus.mem_wdata       = memWdata;
    assign bus.mem_we          = memWe;
    assign bus.mem_re          = memRe;
    assign bus.sp_write_data   = spWdata;
    assign bus.sp_write_enable = spWe;
    assign bus.pop_data        = popData_q;
    assign bus.done            = donePulse;
    assign bus.fault           = BoundsCheck ? faultPulse : 1'b0;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencer that consumes the stack pointer register: reads SP, issues 16-bit data-memory accesses for stack operations, and writes the updated SP back.
- Sits in the memory stage of the five-stage pipeline. Serves PUSH/POP for 16-bit registers and two-word pushes/pops of the 32-bit PC for CALL/RET/INT/RTI.
- Holds the pipeline via op_ready while a multi-cycle operation is in flight.
- The stack grows downward from STACK_TOP.

Parameters:
STACK_TOP, 2047, SP reset value and highest stack word address; pop bound
ADDR_W, 11, data-memory word-address width; mem_addr = low ADDR_W bits of computed address

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; forces IDLE
op_valid  input  1  stack request present this cycle
op  input  3  0 NOP, 1 PUSH16, 2 POP16, 3 PUSH32, 4 POP32; 5-7 treated as NOP
op_data  input  32  push operand; PUSH16 uses [15:0]
op_ready  output  1  1 only in IDLE; a request is accepted when op_valid && op_ready
sp_read_data  input  32  current SP
sp_write_data  output  32  new SP value
sp_write_enable  output  1  SP write strobe, one cycle per completed op
mem_addr  output  ADDR_W  data-memory word address
mem_wdata  output  16  write data
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe; mem_rdata is valid the following cycle
mem_rdata  input  16  read data
pop_data  output  32  registered pop result; held until the next pop completes
done  output  1  one-cycle pulse in an op's final cycle
fault  output  1  one-cycle bounds-fault pulse (see Optional Feature)

Behaviour:
- States: IDLE, PUSH_LO, POP_WAIT, POP_LO_WAIT, POP_HI_WAIT. Reset value is IDLE.
- Reset values: pop_data=0 and all latches 0. With no accepted op, all strobes, done and fault are 0, and mem_addr/mem_wdata are 0.
- Outputs are combinational from state and latches. SP and memory commit on the posedge that ends the cycle.
- On acceptance, SP is latched as S and op_data as D. All addresses are S-relative.
- PUSH16, cycle C (1 cycle):
  - mem_we=1, addr=S, wdata=D[15:0]
  - sp_write_data=S-1, sp_write_enable=1, done=1
  - Stays IDLE, so back-to-back pushes run every cycle.
- PUSH32, 2 cycles:
  - C: write D[31:16] at S; go to PUSH_LO.
  - C+1: write D[15:0] at S-1; SP<=S-2; done=1; go to IDLE.
- POP16, 2 cycles:
  - C: mem_re=1, addr=S+1; go to POP_WAIT.
  - C+1: pop_data<={16'b0, mem_rdata}; SP<=S+1; done=1; go to IDLE.
- POP32, 3 cycles:
  - C: re at S+1 (low word); go to POP_LO_WAIT.
  - C+1: capture low word; re at S+2; go to POP_HI_WAIT.
  - C+2: pop_data<={mem_rdata, low}; SP<=S+2; done=1; go to IDLE.
- SP is written exactly once per op, in its final cycle. Intermediate cycles never write SP.
- A PUSH32 followed by a POP32 restores the original 32-bit value and SP.
- Arithmetic is 32-bit unsigned modulo 2^32; mem_addr truncates to ADDR_W bits.
- op_valid while op_ready=0 is ignored; the requester must hold the request.
- A NOP or illegal op is accepted with no effect and no done pulse.
- Asserting reset mid-op aborts immediately. Memory words already written stay written; SP is not written.

Optional Feature:
- Macro: STACK_BOUNDS_CHECK_EN.
- When defined, checks are evaluated at acceptance:
  - A push of n words (n=1,2) is legal iff S >= n.
  - A pop of n words is legal iff S + n <= STACK_TOP.
- An illegal op produces fault=1 for one cycle. There is no memory access, no SP write and no done; the op is consumed and the block stays IDLE.
- When undefined, there is no check, addresses wrap modulo 2^ADDR_W, and fault is tied to 0.

Test Plan:
- Reset, then SP=2047, PUSH16 D=0x0000ABCD -> mem[2047]=0xABCD, SP=2046, done same cycle, op_ready stays 1.
- SP=2047, PUSH32 D=0x12345678 -> mem[2047]=0x1234, mem[2046]=0x5678, SP=2045 at C+1, op_ready low exactly 1 cycle.
- Continue: POP32 -> reads at 2046 then 2047, pop_data=0x12345678 and SP=2047 at C+2, done single pulse.
- SP=2046, mem[2047]=0x00FF, POP16 -> pop_data=0x000000FF, SP=2047 after 2 cycles; a PUSH16 held during C+1 is accepted at C+2.
- With STACK_BOUNDS_CHECK_EN: SP=2047 POP16 -> fault=1, no mem_re, SP unchanged. SP=1 PUSH32 -> fault. SP=2 PUSH32 -> legal, SP=0.
- Reset asserted at C+1 of POP32 -> state IDLE, no SP write, done=0, pop_data=0, op_ready=1 immediately.
